// File: rtl/sseg_scan_controller.sv
// sseg_scan_controller
//
// Scans a 4-digit common-anode 7-segment display. One digit is lit at a time
// for REFRESH_DIV cycles, optionally followed by BLANK_CYCLES with every anode
// off so the previous digit's segments cannot ghost onto the next one. A new
// BCD word arrives over a valid/ready handshake into a pending buffer. It is
// promoted to the displayed (active) word only when the scan wraps from digit 3
// to digit 0, or at once while idle, so a frame never mixes two words.
//
// Ports
//   clk        - system clock, rising edge
//   reset_n    - asynchronous reset, active low
//   enable     - 1: scan; 0: all anodes off, scan parked at digit 0
//   bcd_in     - four BCD nibbles, [15:12] = digit 3 ... [3:0] = digit 0
//   bcd_valid  - bcd_in offered this cycle
//   bcd_ready  - pending buffer empty; transfer on bcd_valid & bcd_ready
//   bcd_out    - active word for the decoder, leading zeros replaced by 4'hF
//   AN3..AN0   - registered anode strobes, active low, at most one low
//   frame_tick - one-cycle pulse in the first cycle of digit 0 after a wrap

module sseg_scan_controller #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          LZ_SUPPRESS  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] bcd_in,
  input  logic        bcd_valid,
  output logic        bcd_ready,
  output logic [15:0] bcd_out,
  output logic        AN3,
  output logic        AN2,
  output logic        AN1,
  output logic        AN0,
  output logic        frame_tick
);

  localparam int unsigned MaxDiv = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxDiv + 1);
  localparam bit          HasGap = (BLANK_CYCLES > 0);

  // Terminal counts for an N-cycle phase; BlankLast is unused when HasGap is 0.
  localparam logic [CntW-1:0] RefreshLast = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankLast   = CntW'(HasGap ? BLANK_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        an_q, an_d;
  logic              tick_q, tick_d;
  logic [15:0]       pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic [15:0]       act_q, act_d;

  logic              wrap;
  logic              accept;
  logic              commit;

  // Scan sequencing. The prescaler restarts on every phase change.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q + CntW'(1);
    wrap    = 1'b0;

    if (!enable) begin
      state_d = StIdle;
      ptr_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StOn;
          ptr_d   = '0;
          cnt_d   = '0;
        end
        StOn: begin
          if (cnt_q == RefreshLast) begin
            cnt_d = '0;
            if (HasGap) begin
              state_d = StGap;
            end else begin
              ptr_d = ptr_q + 2'd1;
              wrap  = (ptr_q == 2'd3);
            end
          end
        end
        StGap: begin
          if (cnt_q == BlankLast) begin
            cnt_d   = '0;
            state_d = StOn;
            ptr_d   = ptr_q + 2'd1;
            wrap    = (ptr_q == 2'd3);
          end
        end
        default: begin
          state_d = StIdle;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Anodes and frame_tick are decoded from the next state so that the
  // registered strobes line up exactly with the phase they belong to.
  always_comb begin
    an_d = 4'b1111;
    if (state_d == StOn) begin
      unique case (ptr_d)
        2'd0: an_d = 4'b1110;
        2'd1: an_d = 4'b1101;
        2'd2: an_d = 4'b1011;
        2'd3: an_d = 4'b0111;
      endcase
    end
    tick_d = wrap;
  end

  // Double buffer. Accept needs an empty pending slot and commit needs a full
  // one, so the two never happen on the same edge.
  always_comb begin
    accept      = bcd_valid & ~pend_full_q;
    commit      = pend_full_q & ((state_q == StIdle) | wrap);
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    act_d       = act_q;
    if (commit) begin
      act_d       = pend_q;
      pend_full_d = 1'b0;
    end else if (accept) begin
      pend_d      = bcd_in;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cnt_q       <= '0;
      an_q        <= 4'b1111;
      tick_q      <= 1'b0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      act_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      an_q        <= an_d;
      tick_q      <= tick_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      act_q       <= act_d;
    end
  end

  // Leading-zero blanking: a digit is blanked only if it and every more
  // significant digit are zero. Digit 0 always shows. Nibbles above 9 pass
  // through untouched; the decoder renders them blank.
  logic d3_zero, d32_zero, d321_zero;

  always_comb begin
    d3_zero   = (act_q[15:12] == 4'h0);
    d32_zero  = d3_zero && (act_q[11:8] == 4'h0);
    d321_zero = d32_zero && (act_q[7:4] == 4'h0);
    bcd_out   = act_q;
    if (LZ_SUPPRESS) begin
      if (d3_zero)   bcd_out[15:12] = 4'hF;
      if (d32_zero)  bcd_out[11:8]  = 4'hF;
      if (d321_zero) bcd_out[7:4]   = 4'hF;
    end
  end

  assign bcd_ready            = ~pend_full_q;
  assign {AN3, AN2, AN1, AN0} = an_q;
  assign frame_tick           = tick_q;

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Bench for sseg_scan_controller. Three instances share the stimulus:
//   dut 0: REFRESH_DIV=4, BLANK_CYCLES=2, LZ_SUPPRESS=1
//   dut 1: REFRESH_DIV=4, BLANK_CYCLES=0, LZ_SUPPRESS=1
//   dut 2: REFRESH_DIV=4, BLANK_CYCLES=2, LZ_SUPPRESS=0
// A time-based reference model (position in frame = cycles since scan start
// modulo frame length) is compared against every instance on each falling
// edge; directed sequences and two tables cover the documented scenarios.

module tb_sseg_scan_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] bcd_in;
  logic        bcd_valid;

  wire [2:0]        rdy_w;
  wire [2:0]        tick_w;
  wire [2:0][15:0]  out_w;
  wire [2:0][3:0]   an_w;

  always #5 clk = ~clk;

  sseg_scan_controller #(.REFRESH_DIV(4), .BLANK_CYCLES(2), .LZ_SUPPRESS(1'b1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
    .bcd_ready(rdy_w[0]), .bcd_out(out_w[0]), .AN3(an_w[0][3]), .AN2(an_w[0][2]),
    .AN1(an_w[0][1]), .AN0(an_w[0][0]), .frame_tick(tick_w[0])
  );

  sseg_scan_controller #(.REFRESH_DIV(4), .BLANK_CYCLES(0), .LZ_SUPPRESS(1'b1)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
    .bcd_ready(rdy_w[1]), .bcd_out(out_w[1]), .AN3(an_w[1][3]), .AN2(an_w[1][2]),
    .AN1(an_w[1][1]), .AN0(an_w[1][0]), .frame_tick(tick_w[1])
  );

  sseg_scan_controller #(.REFRESH_DIV(4), .BLANK_CYCLES(2), .LZ_SUPPRESS(1'b0)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .enable(enable), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
    .bcd_ready(rdy_w[2]), .bcd_out(out_w[2]), .AN3(an_w[2][3]), .AN2(an_w[2][2]),
    .AN1(an_w[2][1]), .AN0(an_w[2][0]), .frame_tick(tick_w[2])
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  localparam int RefDiv = 4;
  int bl [3]  = '{2, 0, 2};
  bit lzo [3] = '{1'b1, 1'b1, 1'b0};

  bit          m_run  [3];
  int          m_t    [3];
  bit          m_pf   [3];
  logic [15:0] m_pend [3];
  logic [15:0] m_act  [3];

  function automatic int frame_len(input int b);
    return 4 * (RefDiv + b);
  endfunction

  function automatic logic [3:0] exp_an(input bit run, input int t, input int b);
    int pos;
    int digit;
    if (!run) return 4'hF;
    pos   = t % frame_len(b);
    digit = pos / (RefDiv + b);
    if ((pos % (RefDiv + b)) >= RefDiv) return 4'hF;
    return ~(4'b0001 << digit);
  endfunction

  function automatic logic [15:0] lz_ref(input logic [15:0] v, input bit on);
    logic [15:0] r;
    r = v;
    if (on) begin
      for (int i = 3; i >= 1; i--) begin
        if (v[i*4 +: 4] != 4'h0) break;
        r[i*4 +: 4] = 4'hF;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) begin
        m_run[k]  <= 1'b0;
        m_t[k]    <= 0;
        m_pf[k]   <= 1'b0;
        m_pend[k] <= '0;
        m_act[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int tn;
        bit wrap_e;
        tn     = m_run[k] ? m_t[k] + 1 : 0;
        wrap_e = enable && m_run[k] && ((tn % frame_len(bl[k])) == 0);
        m_run[k] <= enable;
        m_t[k]   <= enable ? tn : 0;
        if (m_pf[k] && (!m_run[k] || wrap_e)) begin
          m_act[k] <= m_pend[k];
          m_pf[k]  <= 1'b0;
        end else if (bcd_valid && !m_pf[k]) begin
          m_pend[k] <= bcd_in;
          m_pf[k]   <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("d%0d_an", k), 32'(an_w[k]), 32'(exp_an(m_run[k], m_t[k], bl[k])));
        check($sformatf("d%0d_tick", k), 32'(tick_w[k]),
              32'(m_run[k] && m_t[k] > 0 && (m_t[k] % frame_len(bl[k])) == 0));
        check($sformatf("d%0d_ready", k), 32'(rdy_w[k]), 32'(!m_pf[k]));
        check($sformatf("d%0d_bcd_out", k), 32'(out_w[k]), 32'(lz_ref(m_act[k], lzo[k])));
        check($sformatf("d%0d_one_low", k), 32'($countones(~an_w[k]) <= 1), 32'd1);
      end
    end
  end

  // ---------------- directed tables ----------------
  typedef struct {
    logic [3:0] an;
    logic       tick;
    int         reps;
  } seg_t;

  seg_t seq1 [9] = '{
    '{4'hE, 1'b0, 4}, '{4'hF, 1'b0, 2}, '{4'hD, 1'b0, 4}, '{4'hF, 1'b0, 2},
    '{4'hB, 1'b0, 4}, '{4'hF, 1'b0, 2}, '{4'h7, 1'b0, 4}, '{4'hF, 1'b0, 2},
    '{4'hE, 1'b1, 1}
  };

  typedef struct {
    logic [15:0] val;
    logic [15:0] exp_lz;
    logic [15:0] exp_raw;
  } lz_vec_t;

  lz_vec_t lz_tab [7] = '{
    '{16'h0007, 16'hFFF7, 16'h0007},
    '{16'h0000, 16'hFFF0, 16'h0000},
    '{16'h0102, 16'hF102, 16'h0102},
    '{16'h1000, 16'h1000, 16'h1000},
    '{16'h0010, 16'hFF10, 16'h0010},
    '{16'h00A5, 16'hFFA5, 16'h00A5},
    '{16'h9999, 16'h9999, 16'h9999}
  };

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_an(input string name, input logic [3:0] target, input int budget);
    int n;
    n = 0;
    while (an_w[0] !== target && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(an_w[0]), 32'(target));
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++)
      v[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    int n;
    int idx;
    reset_n   = 1'b0;
    enable    = 1'b0;
    bcd_in    = '0;
    bcd_valid = 1'b0;
    step();
    chk_en = 1'b1;
    step();

    // Reset state
    check("rst_an", 32'(an_w[0]), 32'h0000_000F);
    check("rst_ready", 32'(rdy_w[0]), 32'd1);
    check("rst_tick", 32'(tick_w[0]), 32'd0);
    check("rst_out_lz", 32'(out_w[0]), 32'h0000_FFF0);
    check("rst_out_raw", 32'(out_w[2]), 32'h0000_0000);
    reset_n = 1'b1;
    step();

    // Scan sequence from enable, with and without the blank gap
    enable = 1'b1;
    idx    = 0;
    for (int s = 0; s < 9; s++) begin
      for (int r = 0; r < seq1[s].reps; r++) begin
        step();
        check($sformatf("seq_an[%0d]", idx), 32'(an_w[0]), 32'(seq1[s].an));
        check($sformatf("seq_tick[%0d]", idx), 32'(tick_w[0]), 32'(seq1[s].tick));
        check($sformatf("nogap_lit[%0d]", idx), 32'(an_w[1] != 4'hF), 32'd1);
        check($sformatf("nogap_tick[%0d]", idx), 32'(tick_w[1]), 32'(idx == 16));
        idx++;
      end
    end

    // Handshake mid-frame: held until wrap, second offer dropped
    bcd_valid = 1'b1;
    bcd_in    = 16'h1234;
    step();
    check("hs_ready_drop", 32'(rdy_w[0]), 32'd0);
    check("hs_out_hold", 32'(out_w[0]), 32'h0000_FFF0);
    bcd_in = 16'h5678;
    step();
    bcd_valid = 1'b0;
    bcd_in    = 16'h0000;
    n = 0;
    while (!rdy_w[0] && n < 40) begin
      check("hs_out_until_wrap", 32'(out_w[0]), 32'h0000_FFF0);
      step();
      n++;
    end
    check("hs_ready_rise", 32'(rdy_w[0]), 32'd1);
    check("hs_commit", 32'(out_w[0]), 32'h0000_1234);
    check("hs_commit_tick", 32'(tick_w[0]), 32'd1);
    repeat (30) step();
    check("hs_second_dropped", 32'(out_w[0]), 32'h0000_1234);
    check("hs_ready_kept", 32'(rdy_w[0]), 32'd1);

    // Leading-zero table, loaded through idle commits
    enable = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 7; i++) begin
      bcd_valid = 1'b1;
      bcd_in    = lz_tab[i].val;
      step();
      bcd_valid = 1'b0;
      step();
      check($sformatf("lz_on[%0d]", i), 32'(out_w[0]), 32'(lz_tab[i].exp_lz));
      check($sformatf("lz_off[%0d]", i), 32'(out_w[2]), 32'(lz_tab[i].exp_raw));
    end

    // Enable drop on digit 2 with a pending word, then restart
    enable = 1'b1;
    wait_an("en_reach_d2", 4'hB, 40);
    bcd_valid = 1'b1;
    bcd_in    = 16'h4321;
    step();
    bcd_valid = 1'b0;
    enable    = 1'b0;
    check("en_pending_full", 32'(rdy_w[0]), 32'd0);
    step();
    check("en_off_an", 32'(an_w[0]), 32'h0000_000F);
    step();
    check("en_idle_commit", 32'(out_w[0]), 32'h0000_4321);
    check("en_idle_ready", 32'(rdy_w[0]), 32'd1);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("reen_an[%0d]", i), 32'(an_w[0]), 32'h0000_000E);
      check($sformatf("reen_tick[%0d]", i), 32'(tick_w[0]), 32'd0);
    end
    step();
    check("reen_gap", 32'(an_w[0]), 32'h0000_000F);

    // Asynchronous reset mid-gap with a full pending buffer
    wait_an("ar_reach_d1", 4'hD, 40);
    bcd_valid = 1'b1;
    bcd_in    = 16'h9876;
    step();
    bcd_valid = 1'b0;
    wait_an("ar_reach_gap", 4'hF, 10);
    check("ar_pending_full", 32'(rdy_w[0]), 32'd0);
    #1 reset_n = 1'b0;
    #1;
    check("ar_an", 32'(an_w[0]), 32'h0000_000F);
    check("ar_ready", 32'(rdy_w[0]), 32'd1);
    check("ar_tick", 32'(tick_w[0]), 32'd0);
    check("ar_out", 32'(out_w[0]), 32'h0000_FFF0);
    step();
    reset_n = 1'b1;
    step();

    // Randomized traffic against the model
    for (int c = 0; c < 2500; c++) begin
      if (enable) begin
        if ($urandom_range(0, 79) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        enable = 1'b1;
      end
      bcd_valid = ($urandom_range(0, 7) == 0);
      bcd_in    = rand_bcd();
      if ($urandom_range(0, 499) == 0) begin
        #1 reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end else begin
        step();
      end
    end
    bcd_valid = 1'b0;
    step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
